// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the pixel/result FIFO and its UART consumer.
// master = the consumer that issues pops; slave = the FIFO.
interface fifo_uart_tx_if;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_pop;

   modport master (input fifo_empty, input fifo_rdata, output fifo_pop);
   modport slave  (output fifo_empty, output fifo_rdata, input fifo_pop);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1 UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module fifo_uart_tx #(
   parameter int CLK_FREQ = 125_000_000,
   parameter int BAUD     = 115200,
   parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    shift_reg;
   logic          tx_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          pop;
   logic          bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic          par_reg;
`endif

   // Gated by rst so nothing is popped while the block is held in reset.
   assign pop           = (state_reg == IDLE) && !fifo.fifo_empty && tx_en && !rst;
   assign fifo.fifo_pop = pop;
   assign bit_end       = (cnt_reg == CNT_LAST);
   assign tx            = tx_reg;
   assign tx_busy       = busy_reg;
   assign tx_done       = done_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_reg     <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;

         if (state_reg == IDLE || bit_end)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 1'b1;

         // tx_reg always carries the level for the state being entered.
         case (state_reg)
            IDLE: begin
               tx_reg <= 1'b1;
               if (pop) begin
                  shift_reg <= fifo.fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
                  par_reg   <= ^fifo.fifo_rdata;
`endif
                  state_reg <= START;
                  tx_reg    <= 1'b0;
                  busy_reg  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state_reg   <= DATA;
                  bit_idx_reg <= '0;
                  tx_reg      <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_idx_reg == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     state_reg <= PARITY;
                     tx_reg    <= par_reg;
`else
                     state_reg <= STOP;
                     tx_reg    <= 1'b1;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                     tx_reg      <= shift_reg[1];
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_reg <= STOP;
                  tx_reg    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  tx_reg    <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at BAUD_DIV=4 with a queue-backed show-ahead FIFO model.
// Parity checks are active when FIFO_UART_TX_PARITY_EN is defined.
module tb_fifo_uart_tx;
   localparam int BD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME = FB * BD;

   logic clk = 1'b0;
   logic rst;
   logic tx_en;
   logic tx, tx_busy, tx_done;

   fifo_uart_tx_if ifc ();

   fifo_uart_tx #(.CLK_FREQ(125_000_000), .BAUD(115200), .BAUD_DIV(BD)) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_en   (tx_en),
      .fifo    (ifc.master),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   logic [7:0] q[$];
   logic       pop_prev = 1'b0;
   int         cyc_n = 0;
   int         n_pop = 0;
   int         n_txlow = 0;
   int         vectors = 0;
   int         errors = 0;
   logic       last_par = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      ifc.fifo_empty = (q.size() == 0);
      ifc.fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic settle();
      drive();
      #1;
      pop_prev = ifc.fifo_pop;
   endtask

   // One clock cycle: the model FIFO advances on a pop edge, then outputs are sampled 2 time units later.
   task automatic cyc();
      @(posedge clk);
      if (pop_prev && q.size() != 0) void'(q.pop_front());
      #1;
      drive();
      #1;
      pop_prev = ifc.fifo_pop;
      cyc_n++;
      if (pop_prev) n_pop++;
      if (!tx) n_txlow++;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
`ifdef FIFO_UART_TX_PARITY_EN
      if (j == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Called in the pop cycle; walks the whole frame and the following idle cycle.
   task automatic expect_frame(input logic [7:0] b, input int drop_at, input logic exp_pop_next);
      int j;
      chk("pop_start", 32'(pop_prev), 32'd1);
      for (int i = 0; i < FRAME; i++) begin
         if (i == drop_at) begin
            tx_en = 1'b0;
            settle();
         end
         cyc();
         j = i / BD;
         chk("tx_bit", 32'(tx), 32'(frame_bit(b, j)));
         chk("busy_mid", 32'(tx_busy), 32'd1);
         chk("pop_mid", 32'(pop_prev), 32'd0);
         chk("done_mid", 32'(tx_done), 32'd0);
         if (j == 9 && (i % BD) == 0) last_par = tx;
      end
      cyc();
      chk("tx_idle", 32'(tx), 32'd1);
      chk("done_pulse", 32'(tx_done), 32'd1);
      chk("busy_idle", 32'(tx_busy), 32'd0);
      chk("pop_next", 32'(pop_prev), 32'(exp_pop_next));
      $display("frame %02h sent, ends at cycle %0d", b, cyc_n);
   endtask

   int c1, p0, t0;

   initial begin
      rst   = 1'b1;
      tx_en = 1'b1;
      q.push_back(8'hA5);
      settle();

      // Reset held with a non-empty FIFO
      for (int i = 0; i < 3; i++) cyc();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_pop", 32'(ifc.fifo_pop), 32'd0);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_npop", 32'(n_pop), 32'd0);
      $display("reset checked at cycle %0d", cyc_n);

      // Single byte 0xA5
      rst = 1'b0;
      settle();
      expect_frame(8'hA5, -1, 1'b0);
      chk("single_qempty", 32'(q.size()), 32'd0);

      // Back-to-back 0x00 then 0xFF
      q.push_back(8'h00);
      q.push_back(8'hFF);
      settle();
      c1 = cyc_n;
      expect_frame(8'h00, -1, 1'b1);
      chk("b2b_gap", 32'(cyc_n - c1), 32'(FRAME + 1));
      expect_frame(8'hFF, -1, 1'b0);

      // Empty FIFO for 100 cycles
      settle();
      p0 = n_pop; t0 = n_txlow;
      for (int i = 0; i < 100; i++) cyc();
      chk("empty_npop", 32'(n_pop - p0), 32'd0);
      chk("empty_txlow", 32'(n_txlow - t0), 32'd0);
      $display("empty gating checked at cycle %0d", cyc_n);

      // tx_en low with data waiting
      tx_en = 1'b0;
      q.push_back(8'h11);
      q.push_back(8'h22);
      settle();
      p0 = n_pop; t0 = n_txlow;
      for (int i = 0; i < 100; i++) cyc();
      chk("dis_npop", 32'(n_pop - p0), 32'd0);
      chk("dis_txlow", 32'(n_txlow - t0), 32'd0);
      $display("enable gating checked at cycle %0d", cyc_n);

      // Enable, then drop tx_en mid-frame: frame completes, no further pop
      tx_en = 1'b1;
      settle();
      expect_frame(8'h11, 5, 1'b0);
      p0 = n_pop;
      for (int i = 0; i < 50; i++) cyc();
      chk("drop_npop", 32'(n_pop - p0), 32'd0);
      chk("drop_qsize", 32'(q.size()), 32'd1);
      q.delete();
      tx_en = 1'b1;
      settle();

      // Reset during DATA bit 3 of 0xA5
      q.push_back(8'hA5);
      q.push_back(8'h3C);
      settle();
      chk("mrst_pop", 32'(pop_prev), 32'd1);
      for (int i = 0; i < 18; i++) cyc();
      chk("mrst_bit3", 32'(tx), 32'd0);
      chk("mrst_busy_pre", 32'(tx_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_tx", 32'(tx), 32'd1);
      chk("mrst_busy", 32'(tx_busy), 32'd0);
      chk("mrst_popgate", 32'(ifc.fifo_pop), 32'd0);
      settle();
      cyc();
      cyc();
      chk("mrst_tx_hold", 32'(tx), 32'd1);
      rst = 1'b0;
      settle();
      $display("mid-frame reset checked at cycle %0d", cyc_n);
      expect_frame(8'h3C, -1, 1'b0);

`ifdef FIFO_UART_TX_PARITY_EN
      q.push_back(8'h07);
      q.push_back(8'h03);
      settle();
      c1 = cyc_n;
      expect_frame(8'h07, -1, 1'b1);
      chk("par_07", 32'(last_par), 32'd1);
      chk("par_gap", 32'(cyc_n - c1), 32'd45);
      expect_frame(8'h03, -1, 1'b0);
      chk("par_03", 32'(last_par), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
